bullet_ctrl: RTL and testbench



---
 rtl/bullet_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_bullet_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_ctrl.sv
// Tank shell controller: tracks tank facing, spawns a shell at the muzzle on fire,
// flies it each frame and runs explosion/cooldown. Define BULLET_AUTOFIRE_EN for level-sensitive fire.
module bullet_ctrl #(
  parameter int         BULLET_SPEED    = 4,
  parameter int         BULLET_SIZE     = 4,
  parameter int         EXPLODE_FRAMES  = 8,
  parameter int         COOLDOWN_FRAMES = 16,
  parameter logic [7:0] FIRE_KEY        = 8'h2C
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       gaming_on,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic [7:0] keycode4,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] TankX_Motion,
  input  logic [9:0] TankY_Motion,
  input  logic       BulletHitWall,
  input  logic       BulletHitIron,
  input  logic       BulletHitTank,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic [9:0] BulletS,
  output logic [1:0] BulletDir,
  output logic       Is_bullet_on,
  output logic       Explode_on,
  output logic       Wall_break
);

  localparam logic [9:0]  SPD           = 10'(BULLET_SPEED);
  localparam logic [9:0]  SZ            = 10'(BULLET_SIZE);
  localparam logic [9:0]  LOW_LIMIT     = SZ + SPD;
  localparam logic [9:0]  Y_HIGH        = 10'd479 - SZ;
  localparam logic [9:0]  X_HIGH        = 10'd639 - SZ;
  localparam logic [15:0] EXPLODE_LAST  = 16'(EXPLODE_FRAMES - 1);
  localparam logic [15:0] COOLDOWN_LAST = 16'(COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, FLY, EXPLODE, COOLDOWN} state_t;

  state_t      state;
  logic [1:0]  facing;
  logic [1:0]  facing_next;
  logic        fire_prev;
  logic        fire_now;
  logic        fire_go;
  logic [15:0] explode_cnt;
  logic [15:0] cooldown_cnt;
  logic [10:0] tank_x_fwd;
  logic [10:0] tank_y_fwd;
  logic [9:0]  spawn_x;
  logic [9:0]  spawn_y;
  logic [9:0]  step_x;
  logic [9:0]  step_y;
  logic        out_of_bounds;
  logic        hit_any;

  assign BulletS  = SZ;
  assign fire_now = (keycode == FIRE_KEY) || (keycode2 == FIRE_KEY) ||
                    (keycode3 == FIRE_KEY) || (keycode4 == FIRE_KEY);
`ifdef BULLET_AUTOFIRE_EN
  assign fire_go  = fire_now;
`else
  assign fire_go  = fire_now & ~fire_prev;
`endif
  assign hit_any    = BulletHitTank | BulletHitWall | BulletHitIron;
  assign tank_x_fwd = {1'b0, TankX} + 11'd16;
  assign tank_y_fwd = {1'b0, TankY} + 11'd16;

  // Horizontal motion wins over vertical; no motion keeps the last facing.
  always_comb begin
    facing_next = facing;
    if (TankX_Motion != 10'd0)
      facing_next = TankX_Motion[9] ? 2'd3 : 2'd1;
    else if (TankY_Motion != 10'd0)
      facing_next = TankY_Motion[9] ? 2'd0 : 2'd2;
  end

  always_comb begin
    spawn_x = TankX;
    spawn_y = TankY;
    case (facing)
      2'd0:    spawn_y = (TankY < 10'd16) ? 10'd0 : TankY - 10'd16;
      2'd1:    spawn_x = (tank_x_fwd > 11'd639) ? 10'd639 : tank_x_fwd[9:0];
      2'd2:    spawn_y = (tank_y_fwd > 11'd479) ? 10'd479 : tank_y_fwd[9:0];
      default: spawn_x = (TankX < 10'd16) ? 10'd0 : TankX - 10'd16;
    endcase
  end

  // Bound test is done on the current position so the step itself never wraps.
  always_comb begin
    step_x        = BulletX;
    step_y        = BulletY;
    out_of_bounds = 1'b0;
    case (BulletDir)
      2'd0: begin
        out_of_bounds = BulletY < LOW_LIMIT;
        step_y        = BulletY - SPD;
      end
      2'd1: begin
        out_of_bounds = (BulletX + SPD) > X_HIGH;
        step_x        = BulletX + SPD;
      end
      2'd2: begin
        out_of_bounds = (BulletY + SPD) > Y_HIGH;
        step_y        = BulletY + SPD;
      end
      default: begin
        out_of_bounds = BulletX < LOW_LIMIT;
        step_x        = BulletX - SPD;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      facing       <= 2'd0;
      fire_prev    <= 1'b0;
      explode_cnt  <= 16'd0;
      cooldown_cnt <= 16'd0;
      BulletX      <= 10'd0;
      BulletY      <= 10'd0;
      BulletDir    <= 2'd0;
      Is_bullet_on <= 1'b0;
      Explode_on   <= 1'b0;
      Wall_break   <= 1'b0;
    end else begin
      fire_prev <= fire_now;
      if (!gaming_on) begin
        state        <= IDLE;
        explode_cnt  <= 16'd0;
        cooldown_cnt <= 16'd0;
        BulletX      <= 10'd0;
        BulletY      <= 10'd0;
        BulletDir    <= 2'd0;
        Is_bullet_on <= 1'b0;
        Explode_on   <= 1'b0;
        Wall_break   <= 1'b0;
      end else begin
        facing     <= facing_next;
        Wall_break <= 1'b0;
        case (state)
          IDLE: begin
            if (fire_go) begin
              BulletDir    <= facing;
              BulletX      <= spawn_x;
              BulletY      <= spawn_y;
              Is_bullet_on <= 1'b1;
              state        <= FLY;
            end
          end
          FLY: begin
            if (hit_any || out_of_bounds) begin
              Is_bullet_on <= 1'b0;
              Explode_on   <= 1'b1;
              Wall_break   <= BulletHitWall & ~BulletHitTank;
              explode_cnt  <= 16'd0;
              state        <= EXPLODE;
            end else begin
              BulletX <= step_x;
              BulletY <= step_y;
            end
          end
          EXPLODE: begin
            if (explode_cnt == EXPLODE_LAST) begin
              Explode_on   <= 1'b0;
              cooldown_cnt <= 16'd0;
              state        <= COOLDOWN;
            end else begin
              explode_cnt <= explode_cnt + 16'd1;
            end
          end
          COOLDOWN: begin
            if (cooldown_cnt == COOLDOWN_LAST)
              state <= IDLE;
            else
              cooldown_cnt <= cooldown_cnt + 16'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Scoreboard bench for bullet_ctrl: a frame-level shell model predicts every frame's outputs,
// and a monitor compares them one step after each rising edge.
module tb_bullet_ctrl;

  localparam int         E_FRAMES = 8;
  localparam int         C_FRAMES = 16;
  localparam int         SPEED    = 4;
  localparam int         SIZE     = 4;
  localparam logic [7:0] FK       = 8'h2C;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       gaming_on = 1'b0;
  logic [7:0] keycode = 8'd0, keycode2 = 8'd0, keycode3 = 8'd0, keycode4 = 8'd0;
  logic [9:0] TankX = 10'd0, TankY = 10'd0, TankX_Motion = 10'd0, TankY_Motion = 10'd0;
  logic       BulletHitWall = 1'b0, BulletHitIron = 1'b0, BulletHitTank = 1'b0;
  logic [9:0] BulletX, BulletY, BulletS;
  logic [1:0] BulletDir;
  logic       Is_bullet_on, Explode_on, Wall_break;

  bullet_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .gaming_on(gaming_on),
    .keycode(keycode), .keycode2(keycode2), .keycode3(keycode3), .keycode4(keycode4),
    .TankX(TankX), .TankY(TankY), .TankX_Motion(TankX_Motion), .TankY_Motion(TankY_Motion),
    .BulletHitWall(BulletHitWall), .BulletHitIron(BulletHitIron), .BulletHitTank(BulletHitTank),
    .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS), .BulletDir(BulletDir),
    .Is_bullet_on(Is_bullet_on), .Explode_on(Explode_on), .Wall_break(Wall_break)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int x; int y; int s; int dir; bit on; bit ex; bit wb;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   frame_no = 0;
  bit   mon_en = 1'b0;

  bit         rst_i = 1'b1, gon_i = 1'b0;
  logic [7:0] k1 = 8'd0, k2 = 8'd0, k3 = 8'd0, k4 = 8'd0;
  int         tank_x = 0, tank_y = 0;
  logic [9:0] mx = 10'd0, my = 10'd0;
  bit         hw = 1'b0, hi = 1'b0, ht = 1'b0;

  // Reference model: shell position, in-flight flag, and frames elapsed since the shell ended.
  int m_bx, m_by, m_dir, m_facing, m_since;
  bit m_fly, m_busy, m_wb, m_fire_prev;

  task automatic model_reset();
    m_bx = 0; m_by = 0; m_dir = 0; m_facing = 0; m_since = 0;
    m_fly = 0; m_busy = 0; m_wb = 0; m_fire_prev = 0;
  endtask

  task automatic model_step();
    bit fire_now, fire, leaves;
    if (rst_i) begin
      model_reset();
      return;
    end
    fire_now = (k1 == FK) || (k2 == FK) || (k3 == FK) || (k4 == FK);
`ifdef BULLET_AUTOFIRE_EN
    fire = fire_now;
`else
    fire = fire_now && !m_fire_prev;
`endif
    if (!gon_i) begin
      m_fly = 0; m_busy = 0; m_since = 0; m_bx = 0; m_by = 0; m_dir = 0; m_wb = 0;
    end else begin
      m_wb = 0;
      if (m_fly) begin
        case (m_dir)
          0:       leaves = (m_by - SPEED) < SIZE;
          1:       leaves = (m_bx + SPEED) > 639 - SIZE;
          2:       leaves = (m_by + SPEED) > 479 - SIZE;
          default: leaves = (m_bx - SPEED) < SIZE;
        endcase
        if (ht || hw || hi || leaves) begin
          m_fly = 0; m_busy = 1; m_since = 0;
          m_wb = hw && !ht;
        end else begin
          case (m_dir)
            0:       m_by -= SPEED;
            1:       m_bx += SPEED;
            2:       m_by += SPEED;
            default: m_bx -= SPEED;
          endcase
        end
      end else if (m_busy) begin
        m_since++;
        if (m_since == E_FRAMES + C_FRAMES) m_busy = 0;
      end else if (fire) begin
        m_fly = 1;
        m_dir = m_facing;
        m_bx = tank_x;
        m_by = tank_y;
        case (m_facing)
          0:       m_by = (tank_y - 16 < 0) ? 0 : tank_y - 16;
          1:       m_bx = (tank_x + 16 > 639) ? 639 : tank_x + 16;
          2:       m_by = (tank_y + 16 > 479) ? 479 : tank_y + 16;
          default: m_bx = (tank_x - 16 < 0) ? 0 : tank_x - 16;
        endcase
      end
      if (mx != 10'd0) m_facing = mx[9] ? 3 : 1;
      else if (my != 10'd0) m_facing = my[9] ? 0 : 2;
    end
    m_fire_prev = fire_now;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.x = m_bx; e.y = m_by; e.s = SIZE; e.dir = m_dir;
    e.on = m_fly; e.ex = m_busy && (m_since < E_FRAMES); e.wb = m_wb;
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t g;
    g.x = int'(BulletX); g.y = int'(BulletY); g.s = int'(BulletS); g.dir = int'(BulletDir);
    g.on = Is_bullet_on; g.ex = Explode_on; g.wb = Wall_break;
    return g;
  endfunction

  task automatic check_output(input string name, input exp_t got, input exp_t want);
    n_checks++;
    if (got.x != want.x || got.y != want.y || got.s != want.s || got.dir != want.dir ||
        got.on != want.on || got.ex != want.ex || got.wb != want.wb) begin
      n_fail++;
      $display("[TB] FAIL %s frame=%0d got x=%0d y=%0d s=%0d dir=%0d on=%0b ex=%0b wb=%0b want x=%0d y=%0d s=%0d dir=%0d on=%0b ex=%0b wb=%0b",
               name, frame_no, got.x, got.y, got.s, got.dir, got.on, got.ex, got.wb,
               want.x, want.y, want.s, want.dir, want.on, want.ex, want.wb);
    end
  endtask

  task automatic drive_inputs();
    Reset = rst_i; gaming_on = gon_i;
    keycode = k1; keycode2 = k2; keycode3 = k3; keycode4 = k4;
    TankX = 10'(tank_x); TankY = 10'(tank_y); TankX_Motion = mx; TankY_Motion = my;
    BulletHitWall = hw; BulletHitIron = hi; BulletHitTank = ht;
  endtask

  task automatic apply_stimulus();
    @(negedge frame_clk);
    drive_inputs();
    model_step();
    sb.push_back(model_out());
    mon_en = 1'b1;
    frame_no++;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) apply_stimulus();
  endtask

  task automatic run_until_idle(input int max_frames);
    for (int i = 0; i < max_frames && (m_fly || m_busy); i++) apply_stimulus();
    run_frames(2);
  endtask

  task automatic fire_once(input int which);
    case (which)
      1: k1 = FK; 2: k2 = FK; 3: k3 = FK; default: k4 = FK;
    endcase
    apply_stimulus();
    k1 = 8'd0; k2 = 8'd0; k3 = 8'd0; k4 = 8'd0;
  endtask

  // Reset asserted between edges must clear outputs before the next edge arrives.
  task automatic async_reset_mid();
    exp_t zero;
    @(negedge frame_clk);
    drive_inputs();
    #2;
    rst_i = 1'b1;
    Reset = 1'b1;
    #1;
    model_step();
    zero = model_out();
    check_output("async_reset", dut_out(), zero);
    sb.push_back(zero);
    frame_no++;
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 29);
    if (r == 0) return FK;
    if (r < 8) return 8'($urandom);
    return 8'd0;
  endfunction

  function automatic logic [9:0] rand_motion();
    case ($urandom_range(0, 7))
      0: return 10'h3FF;
      1: return 10'd1;
      2: return 10'h3FC;
      3: return 10'd4;
      default: return 10'd0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge frame_clk);
      #1;
      if (mon_en) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL scoreboard_empty frame=%0d got no expectation want one", frame_no);
        end else begin
          check_output("frame", dut_out(), sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog frame=%0d got timeout want completion", frame_no);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t zero;
    model_reset();
    @(posedge frame_clk);
    #1;
    zero = model_out();
    check_output("reset_state", dut_out(), zero);
    run_frames(2);

    // Fire up from the bottom-left start position, single-frame press on keycode3.
    rst_i = 0; gon_i = 1; tank_x = 48; tank_y = 464;
    run_frames(2);
    fire_once(3);
    run_frames(3);
    run_until_idle(300);

    // Held fire yields exactly one shell.
    k1 = FK;
    run_frames(160);
    k1 = 8'd0;
    run_until_idle(300);

    // Face left, fire, then a one-frame wall hit followed by early and late re-presses.
    tank_x = 100; tank_y = 200; mx = 10'h3FF;
    apply_stimulus();
    mx = 10'd0;
    fire_once(2);
    run_frames(3);
    hw = 1; apply_stimulus(); hw = 0;
    run_frames(9);
    fire_once(4);
    run_frames(14);
    fire_once(4);
    run_frames(3);
    run_until_idle(300);

    // Face down; tank and wall flagged together.
    tank_x = 300; tank_y = 100; my = 10'd1;
    apply_stimulus();
    my = 10'd0;
    fire_once(1);
    run_frames(2);
    hw = 1; ht = 1; apply_stimulus(); hw = 0; ht = 0;
    run_until_idle(60);

    // Reset in flight.
    fire_once(1);
    run_frames(3);
    async_reset_mid();
    run_frames(2);
    rst_i = 0;
    run_frames(2);

    // gaming_on dropped during the explosion.
    tank_x = 320; tank_y = 240;
    fire_once(3);
    run_frames(2);
    hi = 1; apply_stimulus(); hi = 0;
    run_frames(3);
    gon_i = 0;
    run_frames(3);
    gon_i = 1;
    run_frames(3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tank_x = $urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom_range(619, 639);
        tank_y = $urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom_range(459, 479);
      end else begin
        tank_x = $urandom_range(0, 639);
        tank_y = $urandom_range(0, 479);
      end
      mx = rand_motion(); my = rand_motion();
      k1 = rand_key(); k2 = rand_key(); k3 = rand_key(); k4 = rand_key();
      hw = ($urandom_range(0, 39) == 0);
      hi = ($urandom_range(0, 39) == 0);
      ht = ($urandom_range(0, 39) == 0);
      gon_i = ($urandom_range(0, 99) != 0);
      apply_stimulus();
    end

    @(posedge frame_clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
